stream_bp_fifo: RTL and testbench

- Elastic buffer on a valid/backpressure stream link between the router and a stream endpoint: a PE port, the ICAP controller or a PCIe channel. Either direction is supported.
- Absorbs in-flight words after the buffer asserts backpressure, since backpressure is advisory with several cycles of reaction slack.
- Presents a registered output stage that honours downstream backpressure with one-cycle reaction.
- Flags any word lost to overflow.

---
 rtl/stream_bp_fifo.sv | 85 ++++++++
 tb/tb_stream_bp_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bp_fifo.sv
// Elastic buffer for a valid/backpressure stream link: absorbs in-flight words after
// advisory backpressure, delivers through a registered output stage, flags overflow.
module stream_bp_fifo #(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 5,
   parameter int BP_SLACK   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      d,
   input  logic                  d_valid,
   output logic                  d_bp,
   output logic [WIDTH-1:0]      q,
   output logic                  q_valid,
   input  logic                  q_bp,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [DEPTH_LOG2:0] BP_THRESH  = LW'(DEPTH - BP_SLACK);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   level_reg;
   logic [DEPTH_LOG2:0]   level_next;
   logic                  d_bp_reg;
   logic [WIDTH-1:0]      q_reg;
   logic                  q_valid_reg;
   logic                  overflow_reg;
   logic                  wr_en;
   logic                  rd_en;
   logic                  full;

   // Full/empty come from the level counter only; the pointers wrap freely.
   assign full       = (level_reg == LEVEL_FULL);
   assign wr_en      = d_valid && !full;
   assign rd_en      = (level_reg != '0) && !q_bp;
   assign level_next = level_reg + LW'(wr_en) - LW'(rd_en);

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         d_bp_reg     <= 1'b0;
         q_reg        <= '0;
         q_valid_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
         end
         // The RAM read port and the output register are the same stage, so a
         // word written at edge t is readable at edge t+1.
         if (rd_en) begin
            q_reg      <= mem[rd_ptr_reg];
            rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
         end
         q_valid_reg <= rd_en;
         level_reg   <= level_next;
         d_bp_reg    <= (level_next >= BP_THRESH);
         if (d_valid && full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign d_bp     = d_bp_reg;
   assign q        = q_reg;
   assign q_valid  = q_valid_reg;
   assign level    = level_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_stream_bp_fifo.sv
// Directed self-checking bench for stream_bp_fifo at WIDTH=64, DEPTH=32, BP_SLACK=4.
module tb_stream_bp_fifo;

   localparam int WIDTH      = 64;
   localparam int DEPTH_LOG2 = 5;
   localparam int BP_SLACK   = 4;

   logic                clk;
   logic                rst_n;
   logic [WIDTH-1:0]    d;
   logic                d_valid;
   logic                d_bp;
   logic [WIDTH-1:0]    q;
   logic                q_valid;
   logic                q_bp;
   logic [DEPTH_LOG2:0] level;
   logic                overflow;

   int errors = 0;
   int checks = 0;

   stream_bp_fifo #(
      .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BP_SLACK(BP_SLACK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_bp(d_bp),
      .q(q), .q_valid(q_valid), .q_bp(q_bp), .level(level), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Advance one clock; outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; d = 'x; d_valid = 1'b0; q_bp = 1'b0;
      tick(); tick();
      checks++;
      if ({q_valid, d_bp, overflow, level, q} !== '0) begin
         errors++;
         $display("FAIL reset_state: got qv=%b bp=%b ovf=%b lvl=%0d q=%h, want all 0",
                  q_valid, d_bp, overflow, level, q);
      end
      #3 rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (level !== 0 || q_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL x_idle: lvl=%0d qv=%b ovf=%b, want 0 0 0", level, q_valid, overflow);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_word();
      d = 64'h1234; d_valid = 1'b1; q_bp = 1'b0;
      tick();
      d_valid = 1'b0; d = 'x;
      checks++;
      if (level !== 1 || q_valid !== 1'b0 || d_bp !== 1'b0) begin
         errors++;
         $display("FAIL single_t1: lvl=%0d qv=%b bp=%b, want 1 0 0", level, q_valid, d_bp);
      end
      tick();
      checks++;
      if (q_valid !== 1'b1 || q !== 64'h1234 || level !== 0 || d_bp !== 1'b0) begin
         errors++;
         $display("FAIL single_t2: qv=%b q=%h lvl=%0d bp=%b, want 1 1234 0 0", q_valid, q, level, d_bp);
      end
      tick();
      checks++;
      if (q_valid !== 1'b0 || q !== 64'h1234) begin
         errors++;
         $display("FAIL single_t3: qv=%b q=%h, want 0 1234 (held)", q_valid, q);
      end
      $display("test_single_word: q=%h", q);
   endtask

   task automatic test_fill_drain_wrap();
      q_bp = 1'b1;
      for (int i = 0; i < 32; i++) begin
         d = 64'(i); d_valid = 1'b1;
         tick();
         if (i == 26 || i == 27) begin
            checks++;
            if (d_bp !== (i == 27) || level !== 7'(i + 1)) begin
               errors++;
               $display("FAIL fill_bp_%0d: bp=%b lvl=%0d, want %b %0d", i, d_bp, level, (i == 27), i + 1);
            end
         end
      end
      checks++;
      if (level !== 32 || overflow !== 1'b0 || q_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: lvl=%0d ovf=%b qv=%b, want 32 0 0", level, overflow, q_valid);
      end
      d = 64'd999;
      tick();
      d_valid = 1'b0;
      checks++;
      if (level !== 32 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drop: lvl=%0d ovf=%b, want 32 1", level, overflow);
      end
      $display("test_fill: level=%0d overflow=%b", level, overflow);

      q_bp = 1'b0;
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (q_valid !== 1'b1 || q !== 64'(i) || level !== 7'(31 - i) || d_bp !== ((31 - i) >= 28)) begin
            errors++;
            $display("FAIL drain_%0d: qv=%b q=%0d lvl=%0d bp=%b, want 1 %0d %0d %b",
                     i, q_valid, q, level, d_bp, i, 31 - i, ((31 - i) >= 28));
         end
      end
      tick();
      checks++;
      if (q_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL drain_end: qv=%b ovf=%b, want 0 1", q_valid, overflow);
      end
      $display("test_drain: 32 words drained");

      for (int k = 0; k < 42; k++) begin
         d = 64'(100 + k); d_valid = (k < 40);
         tick();
         checks++;
         if (k >= 1 && k <= 40) begin
            if (q_valid !== 1'b1 || q !== 64'(100 + k - 1) || level !== ((k < 40) ? 7'd1 : 7'd0)) begin
               errors++;
               $display("FAIL wrap_%0d: qv=%b q=%0d lvl=%0d, want 1 %0d %0d",
                        k, q_valid, q, level, 100 + k - 1, (k < 40) ? 1 : 0);
            end
         end else if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_%0d: qv=%b, want 0", k, q_valid);
         end
      end
      d_valid = 1'b0;
      $display("test_wrap: 40 words streamed");
   endtask

   task automatic test_qbp_reaction();
      int idx;
      q_bp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d = 64'(200 + i); d_valid = 1'b1;
         tick();
      end
      d_valid = 1'b0;
      idx = 0;
      for (int n = 0; n < 21; n++) begin
         q_bp = (n % 3 == 2);
         tick();
         checks++;
         if (q_bp || idx >= 10) begin
            if (q_valid !== 1'b0) begin
               errors++;
               $display("FAIL qbp_idle_%0d: qv=%b, want 0", n, q_valid);
            end
         end else begin
            if (q_valid !== 1'b1 || q !== 64'(200 + idx)) begin
               errors++;
               $display("FAIL qbp_word_%0d: qv=%b q=%0d, want 1 %0d", n, q_valid, q, 200 + idx);
            end
            idx++;
         end
      end
      q_bp = 1'b0;
      checks++;
      if (level !== 0) begin
         errors++;
         $display("FAIL qbp_level: lvl=%0d, want 0", level);
      end
      $display("test_qbp_reaction: %0d words expected", idx);
   endtask

   task automatic test_full_simul_rw();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      q_bp = 1'b1;
      for (int i = 0; i < 32; i++) begin
         d = 64'(300 + i); d_valid = 1'b1;
         tick();
      end
      checks++;
      if (level !== 32 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL simul_pre: lvl=%0d ovf=%b, want 32 0", level, overflow);
      end
      d = 64'd999; d_valid = 1'b1; q_bp = 1'b0;
      tick();
      d_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 31 || q_valid !== 1'b1 || q !== 64'd300) begin
         errors++;
         $display("FAIL simul_rw: ovf=%b lvl=%0d qv=%b q=%0d, want 1 31 1 300", overflow, level, q_valid, q);
      end
      for (int i = 1; i < 32; i++) begin
         tick();
         checks++;
         if (q_valid !== 1'b1 || q !== 64'(300 + i)) begin
            errors++;
            $display("FAIL simul_drain_%0d: qv=%b q=%0d, want 1 %0d", i, q_valid, q, 300 + i);
         end
      end
      tick();
      checks++;
      if (q_valid !== 1'b0 || level !== 0) begin
         errors++;
         $display("FAIL simul_end: qv=%b lvl=%0d, want 0 0", q_valid, level);
      end
      $display("test_full_simul_rw: overflow=%b", overflow);
   endtask

   task automatic test_reset_mid();
      q_bp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d = 64'(400 + i); d_valid = 1'b1;
         tick();
      end
      d_valid = 1'b0; q_bp = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (q_valid !== 1'b0 || level !== 0 || d_bp !== 1'b0 || overflow !== 1'b0 || q !== '0) begin
         errors++;
         $display("FAIL reset_mid: qv=%b lvl=%0d bp=%b ovf=%b q=%h, want all 0",
                  q_valid, level, d_bp, overflow, q);
      end
      #2 rst_n = 1'b1;
      d = 64'hAA; d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      checks++;
      if (q_valid !== 1'b0 || level !== 1) begin
         errors++;
         $display("FAIL reset_aa_t1: qv=%b lvl=%0d, want 0 1", q_valid, level);
      end
      tick();
      checks++;
      if (q_valid !== 1'b1 || q !== 64'hAA || level !== 0) begin
         errors++;
         $display("FAIL reset_aa_t2: qv=%b q=%h lvl=%0d, want 1 aa 0", q_valid, q, level);
      end
      $display("test_reset_mid: q=%h", q);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill_drain_wrap();
      test_qbp_reaction();
      test_full_simul_rw();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
